// File: rtl/dm_access_arbiter.sv
// Data-memory arbiter: shares one single-ported DM between the MEM stage and a debug/loader
// port, sequencing every access IDLE -> ISSUE -> WAIT -> DONE through a fixed-latency array.
module dm_access_arbiter #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam int unsigned       WCNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned       SCNT_W    = $clog2(STARVE_MAX + 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_LAT - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_MAX);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;      // 0 = CPU, 1 = debug
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [SCNT_W-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic                grant_cpu;
  logic                grant_dbg;
  logic                rdata_cap;

  // Debug is forced only after STARVE_MAX back-to-back CPU grants it had to watch.
  always_comb begin
    grant_cpu = (state_q == IDLE) && cpu_req && !(dbg_req && (starve_q == SCNT_MAX));
    grant_dbg = (state_q == IDLE) && dbg_req && !grant_cpu;
    rdata_cap = (state_q == WAIT) && (wcnt_q == '0) && !we_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_cpu || grant_dbg) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wcnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    if (grant_cpu) begin
      owner_d = 1'b0;
      we_d    = cpu_we;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end else if (grant_dbg) begin
      owner_d = 1'b1;
      we_d    = dbg_we;
      addr_d  = dbg_addr;
      wdata_d = dbg_wdata;
    end

    if (!dbg_req || grant_dbg) begin
      starve_d = '0;
    end else if (grant_cpu && (starve_q != SCNT_MAX)) begin
      starve_d = starve_q + SCNT_W'(1);
    end

    if (state_q == ISSUE) begin
      wcnt_d = WCNT_LOAD;
    end else if ((state_q == WAIT) && (wcnt_q != '0)) begin
      wcnt_d = wcnt_q - WCNT_W'(1);
    end

    if (rdata_cap) begin
      if (owner_q) dbg_rdata_d = mem_rdata;
      else         cpu_rdata_d = mem_rdata;
    end
  end

  // rst gates cpu_stall so every output reads 0 while reset is held.
  always_comb begin
    cpu_stall = rst && cpu_req && !((state_q == DONE) && !owner_q);
    dbg_ack   = (state_q == DONE) && owner_q;
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) checked every cycle
// against a transaction-timing reference model, plus directed scenarios and random traffic.
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [6:0]  cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        cpu_stall [2];
  logic        dbg_req   [2];
  logic        dbg_we    [2];
  logic [6:0]  dbg_addr  [2];
  logic [31:0] dbg_wdata [2];
  logic        dbg_ack   [2];
  logic [31:0] dbg_rdata [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [6:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_l1 (
    .clk(clk), .rst(rst[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_ack(dbg_ack[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  dm_access_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_l3 (
    .clk(clk), .rst(rst[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_ack(dbg_ack[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  function automatic int unsigned lat_of(input int h);
    return (h == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'd9;
    if (i == 1) return 32'd3;
    return 32'(i) * 32'h0103_0507 + 32'h11;
  endfunction

  function automatic string tg(input int h, input string s);
    return $sformatf("h%0d.%s", h, s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Data memory device: write at the issue edge, read data appears MEM_LAT cycles later.
  logic [31:0] dev_mem [2][128];
  logic [31:0] pipe    [2][3];
  bit          mem_ready;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 128; i++) dev_mem[h][i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      for (int h = 0; h < 2; h++)
        if (mem_en[h] && mem_we[h]) dev_mem[h][mem_addr[h]] <= mem_wdata[h];
    end
    for (int h = 0; h < 2; h++) begin
      pipe[h][0] <= dev_mem[h][mem_addr[h]];
      pipe[h][1] <= pipe[h][0];
      pipe[h][2] <= pipe[h][1];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Reference model: one access at a time, timed by cycles elapsed since its grant.
  bit          m_busy  [2];
  int unsigned m_t     [2];
  bit          m_own   [2];   // 1 = debug
  bit          m_we    [2];
  logic [6:0]  m_addr  [2];
  logic [31:0] m_wd    [2];
  logic [31:0] m_cr    [2];
  logic [31:0] m_dr    [2];
  int          m_starve[2];
  logic [31:0] ref_mem [2][128];

  task automatic model_step(input int h);
    int unsigned lat = lat_of(h);
    bit done, e_en, e_stall, gc, gd;
    if (!rst[h]) begin
      m_busy[h] = 1'b0; m_starve[h] = 0; m_cr[h] = '0; m_dr[h] = '0;
    end
    done    = m_busy[h] && (m_t[h] == lat + 2);
    e_en    = m_busy[h] && (m_t[h] == 1);
    e_stall = rst[h] && cpu_req[h] && !(done && !m_own[h]);
    check(tg(h, "mem_en"),    32'(mem_en[h]),    32'(e_en));
    check(tg(h, "mem_we"),    32'(mem_we[h]),    32'(e_en && m_we[h]));
    check(tg(h, "mem_addr"),  32'(mem_addr[h]),  e_en ? 32'(m_addr[h]) : 32'd0);
    check(tg(h, "mem_wdata"), mem_wdata[h],      e_en ? m_wd[h] : 32'd0);
    check(tg(h, "cpu_stall"), 32'(cpu_stall[h]), 32'(e_stall));
    check(tg(h, "dbg_ack"),   32'(dbg_ack[h]),   32'(done && m_own[h]));
    check(tg(h, "cpu_rdata"), cpu_rdata[h],      m_cr[h]);
    check(tg(h, "dbg_rdata"), dbg_rdata[h],      m_dr[h]);
    if (!rst[h]) return;

    gc = !m_busy[h] && cpu_req[h] && !(m_starve[h] == 4 && dbg_req[h]);
    gd = !m_busy[h] && dbg_req[h] && !gc;
    if (!dbg_req[h] || gd) m_starve[h] = 0;
    else if (gc && m_starve[h] < 4) m_starve[h]++;

    if (m_busy[h]) begin
      if (m_t[h] == 1 && m_we[h]) ref_mem[h][m_addr[h]] = m_wd[h];
      if (m_t[h] == lat + 1 && !m_we[h]) begin
        if (m_own[h]) m_dr[h] = ref_mem[h][m_addr[h]];
        else          m_cr[h] = ref_mem[h][m_addr[h]];
      end
      if (done) m_busy[h] = 1'b0;
      else      m_t[h]++;
    end else if (gc || gd) begin
      m_busy[h] = 1'b1;
      m_t[h]    = 1;
      m_own[h]  = gd;
      m_we[h]   = gd ? dbg_we[h]    : cpu_we[h];
      m_addr[h] = gd ? dbg_addr[h]  : cpu_addr[h];
      m_wd[h]   = gd ? dbg_wdata[h] : cpu_wdata[h];
    end
  endtask

  initial begin
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 128; i++) ref_mem[h][i] = init_val(i);
    forever begin
      @(negedge clk);
      for (int h = 0; h < 2; h++) model_step(h);
    end
  end

  task automatic cpu_access(input int h, input bit we, input logic [6:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int n, output bit ok);
    cpu_we[h] = we; cpu_addr[h] = a; cpu_wdata[h] = d; cpu_req[h] = 1'b1;
    ok = 1'b0; rd = '0; n = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!cpu_stall[h]) begin ok = 1'b1; rd = cpu_rdata[h]; n = i; end
    end
    @(posedge clk); #1;
    cpu_req[h] = 1'b0;
  endtask

  task automatic dbg_access(input int h, input bit we, input logic [6:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int n, output bit ok);
    dbg_we[h] = we; dbg_addr[h] = a; dbg_wdata[h] = d; dbg_req[h] = 1'b1;
    ok = 1'b0; rd = '0; n = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dbg_ack[h]) begin ok = 1'b1; rd = dbg_rdata[h]; n = i; end
    end
    @(posedge clk); #1;
    dbg_req[h] = 1'b0;
  endtask

  task automatic new_cpu(input int h);
    cpu_we[h] = 1'($urandom_range(0, 1)); cpu_addr[h] = 7'($urandom_range(0, 15));
    cpu_wdata[h] = $urandom; cpu_req[h] = 1'b1;
  endtask

  task automatic new_dbg(input int h);
    dbg_we[h] = 1'($urandom_range(0, 1)); dbg_addr[h] = 7'($urandom_range(0, 15));
    dbg_wdata[h] = $urandom; dbg_req[h] = 1'b1;
  endtask

  task automatic run(input int h);
    int unsigned lat = lat_of(h);
    logic [31:0] rd;
    logic [9:0]  mask;
    int          n, nfin;
    bit          ok, cfin, dfin;

    cpu_access(h, 1'b0, 7'd0, 32'd0, rd, n, ok);
    check(tg(h, "lw0_done"), 32'(ok), 32'd1);
    check(tg(h, "lw0_rdata"), rd, 32'd9);
    check(tg(h, "lw0_stall_cycles"), 32'(n), 32'(lat + 2));

    cpu_access(h, 1'b1, 7'd5, 32'h1234, rd, n, ok);
    check(tg(h, "sw5_done"), 32'(ok), 32'd1);
    cpu_access(h, 1'b0, 7'd5, 32'd0, rd, n, ok);
    check(tg(h, "lw5_rdata"), rd, 32'h1234);

    dbg_access(h, 1'b0, 7'd1, 32'd0, rd, n, ok);
    check(tg(h, "dbg_rd1_done"), 32'(ok), 32'd1);
    check(tg(h, "dbg_rd1_rdata"), rd, 32'd3);
    check(tg(h, "dbg_rd1_latency"), 32'(n), 32'(lat + 2));

    // Both ports held: every fifth completion must belong to debug.
    cpu_we[h] = 1'b0; cpu_addr[h] = 7'd10; dbg_we[h] = 1'b0; dbg_addr[h] = 7'd20;
    cpu_req[h] = 1'b1; dbg_req[h] = 1'b1;
    nfin = 0; mask = '0;
    for (int i = 0; i < 200 && nfin < 10; i++) begin
      @(negedge clk);
      if (dbg_ack[h]) begin mask[nfin] = 1'b1; nfin++; end
      else if (!cpu_stall[h]) nfin++;
    end
    @(posedge clk); #1;
    cpu_req[h] = 1'b0; dbg_req[h] = 1'b0;
    check(tg(h, "starve_completions"), 32'(nfin), 32'd10);
    check(tg(h, "starve_order"), 32'(mask), 32'(10'b10_0001_0000));

    // Reset in the middle of a CPU load.
    cpu_we[h] = 1'b0; cpu_addr[h] = 7'd0; cpu_req[h] = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst[h] = 1'b0; #1;
    check(tg(h, "rst_mem_en"), 32'(mem_en[h]), 32'd0);
    check(tg(h, "rst_cpu_stall"), 32'(cpu_stall[h]), 32'd0);
    check(tg(h, "rst_dbg_ack"), 32'(dbg_ack[h]), 32'd0);
    check(tg(h, "rst_cpu_rdata"), cpu_rdata[h], 32'd0);
    check(tg(h, "rst_dbg_rdata"), dbg_rdata[h], 32'd0);
    cpu_req[h] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst[h] = 1'b1;
    cpu_access(h, 1'b0, 7'd1, 32'd0, rd, n, ok);
    check(tg(h, "post_rst_lw_rdata"), rd, 32'd3);
    check(tg(h, "post_rst_lw_cycles"), 32'(n), 32'(lat + 2));

    // Store whose requester goes away in the ISSUE cycle; the write must still land.
    cpu_we[h] = 1'b1; cpu_addr[h] = 7'd7; cpu_wdata[h] = 32'hCAFE_0007; cpu_req[h] = 1'b1;
    @(posedge clk); #1;
    cpu_req[h] = 1'b0; cpu_addr[h] = 7'd8; cpu_wdata[h] = 32'hDEAD_BEEF;
    repeat (lat + 4) @(posedge clk);
    #1;
    cpu_access(h, 1'b0, 7'd7, 32'd0, rd, n, ok);
    check(tg(h, "abandoned_sw_rdata"), rd, 32'hCAFE_0007);
    cpu_access(h, 1'b0, 7'd8, 32'd0, rd, n, ok);
    check(tg(h, "abandoned_sw_other_addr"), rd, init_val(8));

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      cfin = cpu_req[h] && !cpu_stall[h];
      dfin = dbg_ack[h];
      @(posedge clk); #1;
      if (cpu_req[h]) begin
        if (cfin) begin
          if ($urandom_range(0, 1) == 1) new_cpu(h);
          else cpu_req[h] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) cpu_req[h] = 1'b0;
        else if ($urandom_range(0, 7) == 0) begin
          cpu_addr[h] = 7'($urandom_range(0, 15)); cpu_wdata[h] = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) new_cpu(h);
      if (dbg_req[h]) begin
        if (dfin) begin
          if ($urandom_range(0, 1) == 1) new_dbg(h);
          else dbg_req[h] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) dbg_req[h] = 1'b0;
        else if ($urandom_range(0, 7) == 0) begin
          dbg_addr[h] = 7'($urandom_range(0, 15)); dbg_wdata[h] = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) new_dbg(h);
    end
    cpu_req[h] = 1'b0; dbg_req[h] = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int h = 0; h < 2; h++) begin
      rst[h] = 1'b0;
      cpu_req[h] = 1'b0; cpu_we[h] = 1'b0; cpu_addr[h] = '0; cpu_wdata[h] = '0;
      dbg_req[h] = 1'b0; dbg_we[h] = 1'b0; dbg_addr[h] = '0; dbg_wdata[h] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); #1;
    fork
      run(0);
      run(1);
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
